// File: rtl/param_issue_queue_pkg.sv
// Shared types for the parametrised issue queue: entry layout,
// opcode constants and datapath widths.
package iq_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int XLEN   = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [PREG_W-1:0] rd;
        logic [PREG_W-1:0] rs1_tag;
        logic [XLEN-1:0]   rs1_val;
        logic              rs1_rdy;
        logic [PREG_W-1:0] rs2_tag;
        logic [XLEN-1:0]   rs2_val;
        logic              rs2_rdy;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [6:0]        opcode;
        logic [XLEN-1:0]   imm;
        logic [ROB_W-1:0]  rob_idx;
    } iq_entry_t;

    function automatic logic ops_ready(input iq_entry_t e);
        return e.rs1_rdy & e.rs2_rdy;
    endfunction

endpackage

// File: rtl/param_issue_queue_select.sv
// Age matrix plus NUM_FU-way oldest-ready picker.
// age[i][j]=1 means entry i was allocated before entry j.
module iq_oldest_select #(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_alloc,
    input  logic [$clog2(DEPTH)-1:0]             i_alloc_idx,
    input  logic [DEPTH-1:0]                     i_free,
    input  logic [DEPTH-1:0]                     i_rdy,
    input  logic [NUM_FU-1:0]                    i_fu_ready,
    output logic [NUM_FU-1:0]                    o_valid,
    output logic [NUM_FU-1:0][$clog2(DEPTH)-1:0] o_idx
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] r_age [DEPTH];
    logic [CW-1:0]    w_rank [DEPTH];
    logic [CW-1:0]    w_fu_rank [NUM_FU];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_reset) begin
                r_age[i] <= '0;
            end else begin
                if (i_free[i]) r_age[i] <= '0;
                if (i_alloc) begin
                    if (IW'(i) == i_alloc_idx) r_age[i] <= '0;
                    else r_age[i][i_alloc_idx] <= 1'b1;
                end
            end
        end
    end

    // rank = number of ready entries older than this one
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_rank[j] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (i_rdy[i] && r_age[i][j]) w_rank[j] = w_rank[j] + CW'(1);
            end
        end
        for (int f = 0; f < NUM_FU; f++) begin
            w_fu_rank[f] = '0;
            for (int g = 0; g < f; g++) begin
                w_fu_rank[f] = w_fu_rank[f] + CW'(i_fu_ready[g]);
            end
        end
    end

    always_comb begin
        o_valid = '0;
        o_idx   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_fu_ready[f] && i_rdy[j] && w_rank[j] == w_fu_rank[f]) begin
                    o_valid[f] = 1'b1;
                    o_idx[f]   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/param_issue_queue.sv
// DEPTH-entry reservation station with wakeup snooping and oldest-first issue.
// Define IQ_PERF_CNT_EN to add the issued / full-stall performance counters.
module param_issue_queue
    import iq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int NUM_FU     = 3,
    parameter int NUM_WAKEUP = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_flush,
    input  logic                                 i_alloc_valid,
    output logic                                 o_alloc_ready,
    input  iq_entry_t                            i_alloc_entry,
    input  logic [NUM_WAKEUP-1:0]                i_wk_valid,
    input  logic [NUM_WAKEUP-1:0][PREG_W-1:0]    i_wk_tag,
    input  logic [NUM_WAKEUP-1:0][XLEN-1:0]      i_wk_val,
    output logic [NUM_FU-1:0]                    o_iss_valid,
    input  logic [NUM_FU-1:0]                    i_iss_ready,
    output iq_entry_t [NUM_FU-1:0]               o_iss_entry,
    output logic [$clog2(DEPTH):0]               o_count
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]                          o_perf_issued,
    output logic [31:0]                          o_perf_full_stall
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]             r_valid;
    iq_entry_t                    r_ent [DEPTH];
    logic [CW-1:0]                r_count;

    logic [DEPTH-1:0]             w_valid_nxt;
    logic [DEPTH-1:0]             w_rdy;
    logic [DEPTH-1:0]             w_free;
    iq_entry_t                    w_ent_nxt [DEPTH];
    iq_entry_t                    w_alloc_ent;
    logic [IW-1:0]                w_slot;
    logic                         w_alloc;
    logic [NUM_FU-1:0]            w_sel_valid;
    logic [NUM_FU-1:0][IW-1:0]    w_sel_idx;
    logic [CW-1:0]                w_n_iss;

    // lowest-index bus wins, so scan downward and let the last hit stick
    function automatic iq_entry_t f_wake(
        input iq_entry_t                         e,
        input logic [NUM_WAKEUP-1:0]             v,
        input logic [NUM_WAKEUP-1:0][PREG_W-1:0] t,
        input logic [NUM_WAKEUP-1:0][XLEN-1:0]   d
    );
        iq_entry_t r;
        r = e;
        for (int b = NUM_WAKEUP - 1; b >= 0; b--) begin
            if (v[b] && !e.rs1_rdy && t[b] == e.rs1_tag) begin
                r.rs1_val = d[b];
                r.rs1_rdy = 1'b1;
            end
            if (v[b] && !e.rs2_rdy && t[b] == e.rs2_tag) begin
                r.rs2_val = d[b];
                r.rs2_rdy = 1'b1;
            end
        end
        return r;
    endfunction

    assign o_alloc_ready = !i_reset && !i_flush && (r_count < CW'(DEPTH));
    assign w_alloc       = i_alloc_valid && o_alloc_ready;
    assign o_iss_valid   = (i_reset || i_flush) ? '0 : w_sel_valid;
    assign o_count       = r_count;

    always_comb begin
        w_slot = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (!r_valid[j]) w_slot = IW'(j);
        end
        w_alloc_ent = f_wake(i_alloc_entry, i_wk_valid, i_wk_tag, i_wk_val);
        for (int j = 0; j < DEPTH; j++) begin
            w_ent_nxt[j] = f_wake(r_ent[j], i_wk_valid, i_wk_tag, i_wk_val);
            w_rdy[j]     = r_valid[j] && ops_ready(r_ent[j]);
        end
        w_free  = '0;
        w_n_iss = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            o_iss_entry[f] = r_ent[w_sel_idx[f]];
            if (o_iss_valid[f]) begin
                w_free[w_sel_idx[f]] = 1'b1;
                w_n_iss = w_n_iss + CW'(1);
            end
        end
        w_valid_nxt = r_valid & ~w_free;
        if (w_alloc) w_valid_nxt[w_slot] = 1'b1;
    end

    iq_oldest_select #(
        .DEPTH (DEPTH),
        .NUM_FU(NUM_FU)
    ) u_sel (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_alloc    (w_alloc),
        .i_alloc_idx(w_slot),
        .i_free     (w_free),
        .i_rdy      (w_rdy),
        .i_fu_ready (i_iss_ready),
        .o_valid    (w_sel_valid),
        .o_idx      (w_sel_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= r_count + CW'(w_alloc) - w_n_iss;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (w_alloc && w_slot == IW'(j)) r_ent[j] <= w_alloc_ent;
            else r_ent[j] <= w_ent_nxt[j];
        end
    end

`ifdef IQ_PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_full_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_issued     <= '0;
            r_perf_full_stall <= '0;
        end else begin
            r_perf_issued <= r_perf_issued + 32'(w_n_iss);
            if (i_alloc_valid && !o_alloc_ready) begin
                r_perf_full_stall <= r_perf_full_stall + 32'd1;
            end
        end
    end

    assign o_perf_issued     = r_perf_issued;
    assign o_perf_full_stall = r_perf_full_stall;
`endif

endmodule

// File: tb/tb_param_issue_queue.sv
// Self-checking bench for param_issue_queue: vector table with
// wakeup bypass cases, then hand sequences for the multi-cycle corners.
module tb_param_issue_queue;
    import iq_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  alloc_valid;
    logic                  alloc_ready;
    iq_entry_t             alloc_entry;
    logic [3:0]            wk_valid;
    logic [3:0][PREG_W-1:0] wk_tag;
    logic [3:0][XLEN-1:0]  wk_val;
    logic [2:0]            iss_valid;
    logic [2:0]            iss_ready;
    iq_entry_t [2:0]       iss_entry;
    logic [4:0]            count;
`ifdef IQ_PERF_CNT_EN
    logic [31:0]           perf_issued;
    logic [31:0]           perf_full_stall;
`endif

    param_issue_queue #(
        .DEPTH(16), .NUM_FU(3), .NUM_WAKEUP(4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_flush      (flush),
        .i_alloc_valid(alloc_valid),
        .o_alloc_ready(alloc_ready),
        .i_alloc_entry(alloc_entry),
        .i_wk_valid   (wk_valid),
        .i_wk_tag     (wk_tag),
        .i_wk_val     (wk_val),
        .o_iss_valid  (iss_valid),
        .i_iss_ready  (iss_ready),
        .o_iss_entry  (iss_entry),
        .o_count      (count)
`ifdef IQ_PERF_CNT_EN
        ,
        .o_perf_issued    (perf_issued),
        .o_perf_full_stall(perf_full_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    typedef struct {
        logic [5:0]       t1;
        logic             r1;
        logic [31:0]      v1;
        logic [5:0]       t2;
        logic             r2;
        logic [31:0]      v2;
        logic [3:0]       wv;
        logic [3:0][5:0]  wt;
        logic [3:0][31:0] wd;
        logic [31:0]      e1;
        logic [31:0]      e2;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic iq_entry_t mk(
        input logic [5:0] rob, input logic [6:0] op,
        input logic [5:0] t1, input logic r1, input logic [31:0] v1,
        input logic [5:0] t2, input logic r2, input logic [31:0] v2
    );
        iq_entry_t e;
        e = '0;
        e.rd = 6'd10;
        e.rs1_tag = t1; e.rs1_rdy = r1; e.rs1_val = r1 ? v1 : 32'h0;
        e.rs2_tag = t2; e.rs2_rdy = r2; e.rs2_val = r2 ? v2 : 32'h0;
        e.funct3 = 3'd2; e.funct7 = 7'h20; e.opcode = op;
        e.imm = 32'h100; e.rob_idx = rob;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        exp_t g;
        for (int f = 0; f < 3; f++) begin
            if (iss_valid[f] && iss_ready[f]) begin
                g.rob = iss_entry[f].rob_idx;
                g.v1  = iss_entry[f].rs1_val;
                g.v2  = iss_entry[f].rs2_val;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_issue fu=%0d rob=%0d", f, g.rob);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        n_bad++;
                        $display("FAIL issue fu=%0d got rob=%0d v1=%h v2=%h exp rob=%0d v1=%h v2=%h",
                                 f, g.rob, g.v1, g.v2, e.rob, e.v1, e.v2);
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] rob, input logic [31:0] v1,
                        input logic [31:0] v2);
        exp_t e;
        e.rob = rob; e.v1 = v1; e.v2 = v2;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        alloc_valid = 1'b0;
        wk_valid = '0;
        wk_tag = '0;
        wk_val = '0;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = '{default: '0};
        tbl[0].t1 = 3;  tbl[0].r1 = 1; tbl[0].v1 = 32'h11;
        tbl[0].t2 = 4;  tbl[0].r2 = 1; tbl[0].v2 = 32'h22;
        tbl[0].e1 = 32'h11; tbl[0].e2 = 32'h22;
        tbl[1].t1 = 7;  tbl[1].t2 = 8; tbl[1].r2 = 1; tbl[1].v2 = 32'h33;
        tbl[1].wv[1] = 1; tbl[1].wt[1] = 7; tbl[1].wd[1] = 32'hDEADBEEF;
        tbl[1].e1 = 32'hDEADBEEF; tbl[1].e2 = 32'h33;
        tbl[2].t1 = 9;  tbl[2].t2 = 9;
        tbl[2].wv[2] = 1; tbl[2].wt[2] = 9; tbl[2].wd[2] = 32'hFFFFFFFF;
        tbl[2].wv[3] = 1; tbl[2].wt[3] = 9; tbl[2].wd[3] = 32'h1;
        tbl[2].e1 = 32'hFFFFFFFF; tbl[2].e2 = 32'hFFFFFFFF;
        tbl[3].t1 = 0;  tbl[3].t2 = 2; tbl[3].r2 = 1; tbl[3].v2 = 32'h44;
        tbl[3].wv[0] = 1; tbl[3].wt[0] = 0; tbl[3].wd[0] = 32'h55;
        tbl[3].e1 = 32'h55; tbl[3].e2 = 32'h44;
        tbl[4].t1 = 12; tbl[4].t2 = 13;
        tbl[4].wv[3] = 1; tbl[4].wt[3] = 12; tbl[4].wd[3] = 32'hA;
        tbl[4].wv[0] = 1; tbl[4].wt[0] = 13; tbl[4].wd[0] = 32'hB;
        tbl[4].e1 = 32'hA; tbl[4].e2 = 32'hB;
        tbl[5].t1 = 20; tbl[5].r1 = 1; tbl[5].v1 = 32'h66;
        tbl[5].t2 = 21; tbl[5].r2 = 1; tbl[5].v2 = 32'h88;
        tbl[5].wv[0] = 1; tbl[5].wt[0] = 20; tbl[5].wd[0] = 32'h77;
        tbl[5].e1 = 32'h66; tbl[5].e2 = 32'h88;

        reset = 1'b1;
        flush = 1'b0;
        iss_ready = 3'b111;
        alloc_entry = '0;
        idle_in();
        cyc();
        chk("reset_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        adv();
        reset = 1'b0;
        cyc();
        chk("post_reset_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("post_reset_count", 64'(count), 64'd0);
        adv();

        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(6'(i + 1), OP_R, tbl[i].t1, tbl[i].r1,
                             tbl[i].v1, tbl[i].t2, tbl[i].r2, tbl[i].v2);
            wk_valid = tbl[i].wv;
            wk_tag = tbl[i].wt;
            wk_val = tbl[i].wd;
            push(6'(i + 1), tbl[i].e1, tbl[i].e2);
            cyc();
            chk("tbl_alloc_ready", 64'(alloc_ready), 64'd1);
            adv();
            idle_in();
            cyc();
            chk("tbl_iss_valid", 64'(iss_valid), 64'b001);
            chk("tbl_count", 64'(count), 64'd1);
            adv();
        end

        alloc_valid = 1'b1;
        alloc_entry = mk(6'd20, OP_I, 6'd5, 1'b0, 32'h0, 6'd5, 1'b0, 32'h0);
        cyc();
        adv();
        idle_in();
        wk_valid[0] = 1'b1; wk_tag[0] = 6'd5; wk_val[0] = 32'hCAFEBABE;
        push(6'd20, 32'hCAFEBABE, 32'hCAFEBABE);
        cyc();
        chk("wake_not_same_cycle", 64'(iss_valid), 64'd0);
        adv();
        idle_in();
        cyc();
        chk("wake_iss_valid", 64'(iss_valid), 64'b001);
        adv();
        cyc();
        chk("wake_count_zero", 64'(count), 64'd0);
        adv();

        alloc_valid = 1'b1;
        alloc_entry = mk(6'd25, OP_LOAD, 6'd9, 1'b0, 32'h0, 6'd9, 1'b0, 32'h0);
        cyc();
        adv();
        idle_in();
        wk_valid = 4'b1100;
        wk_tag[2] = 6'd9; wk_val[2] = 32'hFFFFFFFF;
        wk_tag[3] = 6'd9; wk_val[3] = 32'h1;
        push(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc();
        adv();
        idle_in();
        cyc();
        chk("multibus_iss_valid", 64'(iss_valid), 64'b001);
        adv();

        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(6'(32 + i), OP_STORE, 6'd30, 1'b0, 32'h0,
                             6'd31, 1'b1, 32'(i));
            cyc();
            chk("fill_alloc_ready", 64'(alloc_ready), 64'd1);
            adv();
        end
        alloc_entry = mk(6'd63, OP_STORE, 6'd30, 1'b0, 32'h0,
                         6'd31, 1'b1, 32'hBAD);
        cyc();
        chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        adv();
        idle_in();
        wk_valid[0] = 1'b1; wk_tag[0] = 6'd30; wk_val[0] = 32'h12340000;
        for (int i = 0; i < 16; i++) push(6'(32 + i), 32'h12340000, 32'(i));
        cyc();
        chk("full_drop_count", 64'(count), 64'd16);
        adv();
        idle_in();
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("drain_iss_valid", 64'(iss_valid),
                (c < 5) ? 64'b111 : 64'b001);
            if (c == 0) chk("full_issue_alloc_ready", 64'(alloc_ready), 64'd0);
            adv();
        end
        cyc();
        chk("drain_count", 64'(count), 64'd0);
        adv();

        iss_ready = 3'b000;
        alloc_valid = 1'b1;
        alloc_entry = mk(6'd40, OP_BRANCH, 6'd1, 1'b1, 32'h40, 6'd2, 1'b1, 32'h41);
        cyc();
        adv();
        alloc_entry = mk(6'd41, OP_BRANCH, 6'd1, 1'b1, 32'h50, 6'd2, 1'b1, 32'h51);
        cyc();
        chk("noready_iss_valid", 64'(iss_valid), 64'd0);
        adv();
        idle_in();
        iss_ready = 3'b010;
        push(6'd40, 32'h40, 32'h41);
        cyc();
        chk("fu1_iss_valid", 64'(iss_valid), 64'b010);
        adv();
        iss_ready = 3'b111;
        push(6'd41, 32'h50, 32'h51);
        cyc();
        chk("fu1_younger_count", 64'(count), 64'd1);
        chk("fu1_younger_valid", 64'(iss_valid), 64'b001);
        adv();

        iss_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(6'(50 + i), OP_R, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
            cyc();
            adv();
        end
        flush = 1'b1;
        iss_ready = 3'b111;
        alloc_entry = mk(6'd60, OP_R, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        cyc();
        chk("flush_count_before", 64'(count), 64'd5);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);
        chk("flush_alloc_ready", 64'(alloc_ready), 64'd0);
        adv();
        flush = 1'b0;
        idle_in();
        cyc();
        chk("flush_count_after", 64'(count), 64'd0);
        chk("flush_iss_after", 64'(iss_valid), 64'd0);
        adv();
        for (int c = 0; c < 3; c++) begin
            cyc();
            adv();
        end

        iss_ready = 3'b000;
        for (int i = 0; i < 2; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(6'(44 + i), OP_I, 6'd1, 1'b1, 32'h3, 6'd2, 1'b1, 32'h4);
            cyc();
            adv();
        end
        idle_in();
        reset = 1'b1;
        iss_ready = 3'b111;
        cyc();
        chk("midreset_iss_valid", 64'(iss_valid), 64'd0);
        chk("midreset_alloc_ready", 64'(alloc_ready), 64'd0);
        adv();
        reset = 1'b0;
        cyc();
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_ready_after", 64'(alloc_ready), 64'd1);
        adv();
        for (int c = 0; c < 3; c++) begin
            cyc();
            adv();
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_issue_queue.md
Name: param_issue_queue

Overview:
- Parametrised successor to the single-port issue queue: DEPTH-entry reservation station between rename and the NUM_FU execute units.
- Captures renamed ops with operand values/tags and snoops NUM_WAKEUP result buses to wake waiting operands.
- Each cycle issues up to NUM_FU ready ops, oldest first, through a valid/ready handshake per unit.
- Adds a flush and age-ordered select.

Parameters:
DEPTH, 16, number of queue entries (power of 2, >=2)
NUM_FU, 3, issue ports / functional units
NUM_WAKEUP, 4, forwarding buses (3 FUs + mem)
PREG_W, 6, physical register tag width
ROB_W, 6, ROB index width
XLEN, 32, operand/immediate width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  invalidate all entries (mispredict)
alloc_valid  in  1  rename presents an op
alloc_ready  out  1  queue can accept (count<DEPTH, not reset)
alloc_entry  in  iq_entry_t  rd, rs1/rs2 tags+vals+ready bits, funct3, funct7, opcode, imm, rob_idx
wk_valid  in  NUM_WAKEUP  wakeup bus valid
wk_tag  in  NUM_WAKEUP x PREG_W  produced tag
wk_val  in  NUM_WAKEUP x XLEN  produced value
iss_valid  out  NUM_FU  op presented to unit
iss_ready  in  NUM_FU  unit accepts this cycle
iss_entry  out  NUM_FU x iq_entry_t  issued op, both operands resolved
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: all valid bits 0, count=0, iss_valid=0, alloc_ready=0 during reset, 1 the cycle after.
- Allocation: alloc_valid&alloc_ready writes the lowest-index free slot; entry becomes youngest in the age matrix. alloc_valid without alloc_ready is ignored (no error).
- alloc_ready uses registered count only; a full queue does not accept even if an issue frees a slot the same cycle.
- Wakeup: each cycle, every valid entry with a not-ready source whose tag matches any wk_valid bus latches wk_val and sets ready. Several buses with the same tag: lowest bus index wins.
- Bypass at allocation: the incoming entry also compares against the wakeup buses, so an op allocated in the cycle its producer broadcasts is stored ready.
- Select: combinational over registered state only. Entries woken this cycle become eligible next cycle, so allocate-to-issue latency is 1 cycle minimum.
- The k-th oldest ready entry goes to the k-th unit with iss_ready=1, ascending FU index. iss_valid[i] is 0 when iss_ready[i]=0; this ready-to-valid path is intentional.
- Removal: an entry is freed on iss_valid[i]&iss_ready[i]. Count update = +alloc − issued, in the same cycle.
- Flush: on the next edge all entries are invalidated and count=0. While flush is high, iss_valid and alloc_ready are forced to 0. An alloc in the flush cycle is dropped.
- Reset or flush mid-wakeup: pending wakeups are discarded; no state survives.
- Empty queue: iss_valid=0. A tag of 0 is a normal tag, with no special meaning.

Optional Feature:
- IQ_PERF_CNT_EN defined: adds 32-bit outputs perf_issued (sum of handshakes, wraps) and perf_full_stall (cycles with alloc_valid&!alloc_ready). Both clear on reset, not on flush.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package iq_pkg: iq_entry_t packed struct, opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), PREG_W/ROB_W/XLEN defaults.
- Sub-module iq_oldest_select: age-matrix storage with set-youngest/clear-on-free, plus the NUM_FU-way oldest-ready picker. Instantiated once.

Test Plan:
- Reset then alloc {rd=10, rs1=5, rs2=5 not ready, rob=20}; wk bus0 tag5=0xCAFEBABE next cycle -> following cycle iss_valid[0]=1, rs1_val=rs2_val=0xCAFEBABE, rob=20, count returns 0.
- Same-cycle bypass: alloc rs1=7 while bus1 broadcasts tag7=0xDEADBEEF -> issued next cycle with rs1_val=0xDEADBEEF.
- Fill 16 ready-less entries -> alloc_ready=0, count=16. 17th alloc dropped. Wake all -> three oldest issued per cycle in allocation order, queue empty after 6 cycles.
- iss_ready=3'b010 with two ready entries -> oldest appears on FU1 only, iss_valid=3'b010, younger stays.
- Flush with 5 valid entries plus a simultaneous alloc -> iss_valid=0 that cycle, count=0 next, no later issue.
- Tag 9 broadcast on buses 2 and 3 (0xFFFFFFFF, 0x1) -> entry captures 0xFFFFFFFF (lower bus).
